// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg
// Shared definitions for the SAR conversion sequencer:
//   - default resolution, sample length and comparator timeout
//   - sequencer state encoding
//   - comparator decision codes, formed as {sp, sn} from the synchronized
//     comparator outputs
// ---------------------------------------------------------------------------
package sar_pkg;

   localparam int NBITS_DEF         = 10;
   localparam int SAMPLE_CYCLES_DEF = 4;
   localparam int CMP_TIMEOUT_DEF   = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_FIRE,
      ST_PRECHG,
      ST_DONE
   } state_t;

   // A dynamic comparator rests at 11 while precharged and drops exactly one
   // side when it resolves; 00 is an unresolved/metastable-looking reading.
   typedef enum logic [1:0] {
      CMP_NONE  = 2'b00,
      CMP_CLEAR = 2'b01,
      CMP_KEEP  = 2'b10,
      CMP_PRECH = 2'b11
   } cmp_t;

endpackage

// File: rtl/sar_cmp_sync.sv
// ---------------------------------------------------------------------------
// sar_cmp_sync
// Two-stage synchronizer for the comparator output pair, which toggles
// asynchronously to clk.
// Ports:
//   clk   - sequencer clock
//   reset - synchronous, active-high
//   din   - raw {outp, outn}
//   dout  - synchronized {sp, sn}
// ---------------------------------------------------------------------------
module sar_cmp_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   logic [1:0] meta;

   // Resetting to 11 matches the comparator's precharged resting state, so
   // the sequencer never sees a phantom decision straight out of reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 2'b11;
         dout <= 2'b11;
      end else begin
         meta <= din;
         dout <= meta;
      end
   end

endmodule

// File: rtl/sar_sequencer.sv
// ---------------------------------------------------------------------------
// sar_sequencer
// Successive-approximation conversion sequencer: samples the input, then
// walks the CDAC trial code MSB-first using a dynamic comparator, with a
// per-phase timeout so a stuck comparator cannot hang a conversion.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start       - conversion request, only honoured in IDLE
//   outp, outn  - asynchronous comparator outputs
//   clks        - sample-switch enable
//   clkc        - comparator evaluate (1) / precharge (0)
//   dac_code    - trial code to the CDAC
//   data        - last completed result
//   valid       - one-cycle result pulse
//   busy        - conversion in progress
//   err         - comparator timeout seen during the current/last conversion
// ---------------------------------------------------------------------------
module sar_sequencer
   import sar_pkg::*;
#(
   parameter int NBITS         = NBITS_DEF,
   parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
   parameter int CMP_TIMEOUT   = CMP_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             outp,
   input  logic             outn,
   output logic             clks,
   output logic             clkc,
   output logic [NBITS-1:0] dac_code,
   output logic [NBITS-1:0] data,
   output logic             valid,
   output logic             busy,
   output logic             err
);

   localparam int CNT_MAX = (SAMPLE_CYCLES > CMP_TIMEOUT) ? SAMPLE_CYCLES : CMP_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int K_W     = (NBITS > 1) ? $clog2(NBITS) : 1;

   state_t             state, state_nxt;
   logic [K_W-1:0]     k, k_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               clks_nxt, clkc_nxt, valid_nxt, busy_nxt, err_nxt;
   logic [NBITS-1:0]   dac_nxt, data_nxt;
   logic [1:0]         sync_pair;
   cmp_t               cmp;
   logic               timeout;

   sar_cmp_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .din   ({outp, outn}),
      .dout  (sync_pair)
   );

   assign cmp     = cmp_t'(sync_pair);
   assign timeout = (cnt == CNT_W'(CMP_TIMEOUT - 1));

   // Every output is a register; the next-state logic below computes the
   // value each one takes on the coming edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         k        <= '0;
         cnt      <= '0;
         clks     <= 1'b0;
         clkc     <= 1'b0;
         dac_code <= '0;
         data     <= '0;
         valid    <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         k        <= k_nxt;
         cnt      <= cnt_nxt;
         clks     <= clks_nxt;
         clkc     <= clkc_nxt;
         dac_code <= dac_nxt;
         data     <= data_nxt;
         valid    <= valid_nxt;
         busy     <= busy_nxt;
         err      <= err_nxt;
      end
   end

   // Next-state and output logic. The counter times the sample window and is
   // then reused as the per-visit timeout for each comparator phase. A FIRE
   // timeout treats the bit as "Vin below DAC", which biases a dead
   // comparator toward an all-zero result rather than a random one.
   always_comb begin
      state_nxt = state;
      k_nxt     = k;
      cnt_nxt   = cnt;
      clks_nxt  = clks;
      clkc_nxt  = clkc;
      dac_nxt   = dac_code;
      data_nxt  = data;
      valid_nxt = 1'b0;
      busy_nxt  = busy;
      err_nxt   = err;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_SAMPLE;
               busy_nxt  = 1'b1;
               clks_nxt  = 1'b1;
               err_nxt   = 1'b0;
               cnt_nxt   = '0;
            end
         end

         ST_SAMPLE: begin
            if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
               state_nxt          = ST_FIRE;
               clks_nxt           = 1'b0;
               clkc_nxt           = 1'b1;
               dac_nxt            = '0;
               dac_nxt[NBITS-1]   = 1'b1;
               k_nxt              = K_W'(NBITS - 1);
               cnt_nxt            = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         ST_FIRE: begin
            if (cmp == CMP_KEEP || cmp == CMP_CLEAR || timeout) begin
               if (cmp != CMP_KEEP) begin
                  dac_nxt[k] = 1'b0;
               end
               if (cmp != CMP_KEEP && cmp != CMP_CLEAR) begin
                  err_nxt = 1'b1;
               end
               state_nxt = ST_PRECHG;
               clkc_nxt  = 1'b0;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         ST_PRECHG: begin
            if (cmp == CMP_PRECH || timeout) begin
               if (cmp != CMP_PRECH) begin
                  err_nxt = 1'b1;
               end
               cnt_nxt = '0;
               if (k == '0) begin
                  state_nxt = ST_DONE;
               end else begin
                  dac_nxt[k - K_W'(1)] = 1'b1;
                  k_nxt                = k - K_W'(1);
                  state_nxt            = ST_FIRE;
                  clkc_nxt             = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end

         ST_DONE: begin
            data_nxt  = dac_code;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule
